// File: rtl/debounce_multi_pkg.sv
// Shared defaults for the multi-channel push-button debouncer.
package debounce_multi_pkg;

  // Board clock and the time base the filters are usually run at.
  localparam int unsigned BoardClkHz = 50_000_000;
  localparam int unsigned TickHz     = 1_000;

  // Cycles per tick for a given clock, clamped to the prescaler's 16-bit range.
  function automatic int unsigned prescale_for(int unsigned clk_hz, int unsigned tick_hz);
    int unsigned p;
    p = clk_hz / tick_hz;
    if (p < 1) p = 1;
    if (p > 65535) p = 65535;
    return p;
  endfunction

  localparam int unsigned DefPrescale    = prescale_for(BoardClkHz, TickHz);
  localparam int unsigned DefCntW        = 16;
  localparam int unsigned DefHoldW       = 8;
  localparam int unsigned DefHoldTicks   = 200;
  localparam int unsigned DefRepeatTicks = 50;

  // Strobe kinds; the numeric order matches the bit order used by observers.
  typedef enum logic [1:0] {
    EvDown   = 2'd0,
    EvUp     = 2'd1,
    EvLong   = 2'd2,
    EvRepeat = 2'd3
  } btn_event_e;

endpackage

// File: rtl/debounce_multi_if.sv
// Button pins in, debounced levels and strobes out.
interface debounce_multi_if #(
  parameter int unsigned N = 4
) ();

  logic [N-1:0] btn;
  logic         repeat_en;
  logic [N-1:0] btn_state;
  logic [N-1:0] btn_down;
  logic [N-1:0] btn_up;
  logic [N-1:0] btn_long;
  logic [N-1:0] btn_repeat;

  // Board side: drives the raw pins and the repeat enable.
  modport master (
    output btn, repeat_en,
    input  btn_state, btn_down, btn_up, btn_long, btn_repeat
  );

  // Debouncer side.
  modport slave (
    input  btn, repeat_en,
    output btn_state, btn_down, btn_up, btn_long, btn_repeat
  );

endinterface

// File: rtl/debounce_prescaler.sv
// Free-running time-base tick shared by all debouncer channels.
module debounce_prescaler #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic tick_o
);

  localparam int unsigned CntW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(PRESCALE - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Count 0..PRESCALE-1 and tick on the last value; PRESCALE=1 ticks every cycle.
  always_comb begin
    tick_o = (cnt_q == CntLast);
    cnt_d  = tick_o ? '0 : cnt_q + 1'b1;
  end

  // Counter state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/debounce_multi.sv
// N-channel push-button debouncer with press/release, long-press and auto-repeat strobes.
module debounce_multi
  import debounce_multi_pkg::*;
#(
  parameter int unsigned N            = 4,
  parameter int unsigned INVERT       = 1,
  parameter int unsigned PRESCALE     = 1,
  parameter int unsigned CNT_W        = DefCntW,
  parameter int unsigned HOLD_W       = DefHoldW,
  parameter int unsigned HOLD_TICKS   = DefHoldTicks,
  parameter int unsigned REPEAT_TICKS = DefRepeatTicks
) (
  input logic             clk,
  input logic             rst_n,
  debounce_multi_if.slave bus
);

  localparam logic              InvBit   = (INVERT != 0);
  localparam logic [HOLD_W-1:0] HoldLast = HOLD_W'(HOLD_TICKS - 1);
  localparam logic [HOLD_W-1:0] RepLast  = HOLD_W'(REPEAT_TICKS - 1);

  logic         tick;
  logic [N-1:0] state_vec, down_vec, up_vec, long_vec, rep_vec;

  debounce_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .tick_o (tick)
  );

  for (genvar i = 0; i < N; i++) begin : g_ch
    logic              sync0_q, sync1_q;
    logic              state_q, state_d;
    logic              down_q, down_d, up_q, up_d;
    logic              long_q, long_d, rep_q, rep_d;
    logic              long_flag_q, long_flag_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              idle, accept;

    // Debounce filter: any agreement with the current level restarts the count.
    always_comb begin
      idle    = (sync1_q == state_q);
      accept  = !idle && tick && (cnt_q == '1);
      cnt_d   = cnt_q;
      if (idle) begin
        cnt_d = '0;
      end else if (tick) begin
        cnt_d = accept ? '0 : cnt_q + 1'b1;
      end
      state_d = accept ? ~state_q : state_q;
      down_d  = accept && !state_q;
      up_d    = accept && state_q;
    end

    // Hold timing: long press first, then repeats; an accepted release overrides both.
    always_comb begin
      hold_d      = hold_q;
      long_flag_d = long_flag_q;
      long_d      = 1'b0;
      rep_d       = 1'b0;
      if (!state_q || up_d) begin
        hold_d      = '0;
        long_flag_d = 1'b0;
      end else if (tick) begin
        if (!long_flag_q) begin
          if (hold_q == HoldLast) begin
            long_d      = 1'b1;
            long_flag_d = 1'b1;
            hold_d      = '0;
          end else if (hold_q != '1) begin
            hold_d = hold_q + 1'b1;
          end
        end else begin
          // With repeat disabled the count parks at the threshold.
          if (hold_q == RepLast) begin
            if (bus.repeat_en) begin
              rep_d  = 1'b1;
              hold_d = '0;
            end
          end else if (hold_q != '1) begin
            hold_d = hold_q + 1'b1;
          end
        end
      end
    end

    // Per-channel state; sync stage 0 applies the pin polarity so 0 means released.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync0_q     <= 1'b0;
        sync1_q     <= 1'b0;
        state_q     <= 1'b0;
        down_q      <= 1'b0;
        up_q        <= 1'b0;
        long_q      <= 1'b0;
        rep_q       <= 1'b0;
        long_flag_q <= 1'b0;
        cnt_q       <= '0;
        hold_q      <= '0;
      end else begin
        sync0_q     <= bus.btn[i] ^ InvBit;
        sync1_q     <= sync0_q;
        state_q     <= state_d;
        down_q      <= down_d;
        up_q        <= up_d;
        long_q      <= long_d;
        rep_q       <= rep_d;
        long_flag_q <= long_flag_d;
        cnt_q       <= cnt_d;
        hold_q      <= hold_d;
      end
    end

    assign state_vec[i] = state_q;
    assign down_vec[i]  = down_q;
    assign up_vec[i]    = up_q;
    assign long_vec[i]  = long_q;
    assign rep_vec[i]   = rep_q;
  end

  assign bus.btn_state  = state_vec;
  assign bus.btn_down   = down_vec;
  assign bus.btn_up     = up_vec;
  assign bus.btn_long   = long_vec;
  assign bus.btn_repeat = rep_vec;

endmodule

// File: tb/tb_debounce_multi.sv
// Directed bench for debounce_multi: two instances, strobes tracked by an event scoreboard.
module tb_debounce_multi;
  import debounce_multi_pkg::*;

  localparam int unsigned LatA  = 2 + 16;  // PRESCALE=1, CNT_W=4
  localparam int unsigned HoldA = 5;
  localparam int unsigned RepA  = 3;
  localparam int unsigned PreB  = 4;
  localparam int unsigned CntWB = 2;

  typedef struct {
    int         cyc;
    int         ch;     // 0..1 instance A, 2 instance B
    btn_event_e kind;
  } exp_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  int          cyc   = 0;
  int          pre_m;
  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];

  debounce_multi_if #(.N(2)) bus_a ();
  debounce_multi_if #(.N(1)) bus_b ();

  debounce_multi #(
    .N(2), .INVERT(1), .PRESCALE(1), .CNT_W(4), .HOLD_W(8),
    .HOLD_TICKS(HoldA), .REPEAT_TICKS(RepA)
  ) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  debounce_multi #(
    .N(1), .INVERT(0), .PRESCALE(PreB), .CNT_W(CntWB), .HOLD_W(8),
    .HOLD_TICKS(200), .REPEAT_TICKS(50)
  ) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference time base for instance B.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pre_m <= 0;
    else        pre_m <= (pre_m == PreB - 1) ? 0 : pre_m + 1;
  end

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push(input int c, input int ch, input btn_event_e kind);
    exp_t e;
    e.cyc  = c;
    e.ch   = ch;
    e.kind = kind;
    sb.push_back(e);
  endtask

  // Called only at #1 after a rising edge.
  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_drain"}, sb.size(), 0);
  endtask

  // Edges from a pin change on B to acceptance: 2 sync edges then 2^CNT_W ticks.
  function automatic int b_lat(input int p);
    int n;
    n = 0;
    for (int j = 3; j < 200; j++) begin
      if (((p + j - 1) % PreB) == PreB - 1) begin
        n++;
        if (n == (1 << CntWB)) return j;
      end
    end
    return 0;
  endfunction

  function automatic logic strobe(input int ch, input int k);
    logic [3:0] v;
    if (ch < 2) begin
      v = {bus_a.btn_repeat[ch], bus_a.btn_long[ch], bus_a.btn_up[ch], bus_a.btn_down[ch]};
    end else begin
      v = {bus_b.btn_repeat[0], bus_b.btn_long[0], bus_b.btn_up[0], bus_b.btn_down[0]};
    end
    return v[k];
  endfunction

  // Scoreboard: every strobe seen must match the oldest expected event.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int ch = 0; ch < 3; ch++) begin
          for (int k = 0; k < 4; k++) begin
            if (strobe(ch, k)) begin
              if (sb.size() == 0) begin
                check($sformatf("sb_unexpected_ch%0d_ev%0d", ch, k), cyc, -1);
              end else begin
                e = sb.pop_front();
                check("sb_cycle", cyc, e.cyc);
                check("sb_event", ch * 4 + k, e.ch * 4 + int'(e.kind));
              end
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int k, a, d, r, m, p, lat;
    bus_a.btn       = 2'b11;
    bus_a.repeat_en = 1'b0;
    bus_b.btn       = 1'b0;
    bus_b.repeat_en = 1'b0;
    rst_n           = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state_a", bus_a.btn_state, 0);
    check("rst_down_a", bus_a.btn_down, 0);
    check("rst_up_a", bus_a.btn_up, 0);
    check("rst_long_a", bus_a.btn_long, 0);
    check("rst_repeat_a", bus_a.btn_repeat, 0);
    check("rst_state_b", bus_b.btn_state, 0);
    rst_n = 1'b1;
    goto(cyc + 5);

    // Press ch0 with repeat disabled: down after LatA, long only.
    k = cyc;
    bus_a.btn[0] = 1'b0;
    push(k + LatA, 0, EvDown);
    push(k + LatA + HoldA, 0, EvLong);
    goto(k + LatA - 1);
    check("t1_state_before", bus_a.btn_state, 0);
    goto(k + LatA);
    check("t1_state_after", bus_a.btn_state, 2'b01);
    check("t1_down", bus_a.btn_down, 2'b01);
    goto(k + LatA + 1);
    check("t1_down_one_cycle", bus_a.btn_down, 0);
    goto(k + 40);
    r = cyc;
    bus_a.btn[0] = 1'b1;
    push(r + LatA, 0, EvUp);
    goto(r + LatA);
    check("t1_release_state", bus_a.btn_state, 0);
    check("t1_up", bus_a.btn_up, 2'b01);
    drain("t1");

    // 10-cycle glitch is rejected.
    k = cyc;
    bus_a.btn[0] = 1'b0;
    goto(k + 10);
    bus_a.btn[0] = 1'b1;
    goto(k + 40);
    check("t2_glitch_state", bus_a.btn_state, 0);

    // 15-cycle glitch, 1-cycle gap, then hold: acceptance counts from the final edge.
    k = cyc;
    bus_a.btn[0] = 1'b0;
    goto(k + 15);
    bus_a.btn[0] = 1'b1;
    goto(k + 16);
    bus_a.btn[0] = 1'b0;
    bus_a.repeat_en = 1'b1;
    a = k + 16 + LatA;
    push(a, 0, EvDown);
    push(a + HoldA, 0, EvLong);
    for (int t = HoldA + RepA; t <= 20; t += RepA) push(a + t, 0, EvRepeat);
    goto(a - 1);
    check("t2_early_state", bus_a.btn_state, 0);
    // Release so its acceptance lands on the next repeat threshold.
    goto(a + 5);
    bus_a.btn[0] = 1'b1;
    push(a + 23, 0, EvUp);
    goto(a + 22);
    check("t3_held_state", bus_a.btn_state, 2'b01);
    goto(a + 23);
    check("t3_up_wins", bus_a.btn_up, 2'b01);
    check("t3_no_repeat", bus_a.btn_repeat, 0);
    drain("t3");

    // Long flag was cleared: next press needs the full hold time again.
    k = cyc;
    bus_a.btn[0] = 1'b0;
    d = k + LatA;
    push(d, 0, EvDown);
    push(d + HoldA, 0, EvLong);
    push(d + HoldA + RepA, 0, EvRepeat);
    goto(d + HoldA + RepA);
    check("t4_repeat", bus_a.btn_repeat, 2'b01);
    bus_a.repeat_en = 1'b0;
    goto(d + 14);
    r = cyc;
    bus_a.btn[0] = 1'b1;
    push(r + LatA, 0, EvUp);
    drain("t4");

    // Channel 1 alone; channel 0 must stay quiet.
    k = cyc;
    bus_a.btn[1] = 1'b0;
    push(k + LatA, 1, EvDown);
    push(k + LatA + HoldA, 1, EvLong);
    goto(k + LatA);
    check("t5_ch1_state", bus_a.btn_state, 2'b10);
    goto(k + 20);
    bus_a.btn[1] = 1'b1;
    push(k + 20 + LatA, 1, EvUp);
    drain("t5");

    // Asynchronous reset mid-press, pin kept pressed through it.
    k = cyc;
    bus_a.btn[0] = 1'b0;
    push(k + LatA, 0, EvDown);
    goto(k + 20);
    check("t6_pressed", bus_a.btn_state, 2'b01);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_state", bus_a.btn_state, 0);
    check("t6_async_long", bus_a.btn_long, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    r = cyc;
    push(r + LatA, 0, EvDown);
    push(r + LatA + HoldA, 0, EvLong);
    goto(r + LatA - 1);
    check("t6_refilter_before", bus_a.btn_state, 0);
    goto(r + LatA);
    check("t6_refilter_after", bus_a.btn_state, 2'b01);
    goto(r + 19);
    bus_a.btn[0] = 1'b1;
    push(r + 19 + LatA, 0, EvUp);
    drain("t6");

    // Instance B: PRESCALE=4, CNT_W=2, active-high pin.
    k = cyc;
    p = pre_m;
    lat = b_lat(p);
    bus_b.btn = 1'b1;
    push(k + lat, 2, EvDown);
    goto(k + lat - 1);
    check("t7_b_before", bus_b.btn_state, 0);
    goto(k + lat);
    check("t7_b_after", bus_b.btn_state, 1);
    check("t7_b_down", bus_b.btn_down, 1);
    // Short release: restarts the filter, no strobe.
    goto(k + lat + 3);
    m = cyc;
    bus_b.btn = 1'b0;
    goto(m + 6);
    bus_b.btn = 1'b1;
    goto(m + 30);
    check("t8_b_still_pressed", bus_b.btn_state, 1);
    k = cyc;
    p = pre_m;
    lat = b_lat(p);
    bus_b.btn = 1'b0;
    push(k + lat, 2, EvUp);
    goto(k + lat - 1);
    check("t8_b_release_before", bus_b.btn_state, 1);
    goto(k + lat);
    check("t8_b_release_after", bus_b.btn_state, 0);
    drain("t8");

    goto(cyc + 10);
    check("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
